// File: rtl/laser_hit_detect_pkg.sv
// Shared constants for the laser hit detector: geometry defaults, score
// increment, coordinate/edge widths and the scan FSM state encoding.
package laser_hit_detect_pkg;

    localparam int DEF_NUM_INVADERS  = 6;
    localparam int DEF_INV_W         = 32;
    localparam int DEF_INV_H         = 32;
    localparam int DEF_INV_PITCH     = 48;
    localparam int DEF_LASER_W       = 4;
    localparam int DEF_LASER_H       = 16;
    localparam int DEF_SCORE_PER_HIT = 10;

    // Screen coordinates are 10 bits; edge sums carry one extra bit so that
    // right/bottom edges past 1023 never wrap.
    localparam int COORD_W = 10;
    localparam int EDGE_W  = 11;
    localparam int SCORE_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LATCH  = 2'd1,
        ST_SCAN   = 2'd2,
        ST_REPORT = 2'd3
    } hit_state_t;

endpackage

// File: rtl/laser_hit_detect_rect_overlap.sv
// Combinational overlap test of two axis-aligned rectangles. Rectangle A is
// at (a_x, a_y) with size A_W x A_H, rectangle B at (b_x, b_y) with size
// B_W x B_H. Right/bottom edges are formed as 11-bit sums and all compares
// are unsigned; edges are exclusive, so touching rectangles do not overlap.
module rect_overlap
    import laser_hit_detect_pkg::*;
#(
    parameter int A_W = DEF_LASER_W,
    parameter int A_H = DEF_LASER_H,
    parameter int B_W = DEF_INV_W,
    parameter int B_H = DEF_INV_H
) (
    input  logic [EDGE_W-1:0] a_x,
    input  logic [EDGE_W-1:0] a_y,
    input  logic [EDGE_W-1:0] b_x,
    input  logic [EDGE_W-1:0] b_y,
    output logic              overlap
);

    logic [EDGE_W-1:0] a_right;
    logic [EDGE_W-1:0] a_bottom;
    logic [EDGE_W-1:0] b_right;
    logic [EDGE_W-1:0] b_bottom;

    // Far edges of both rectangles, then the four separating-axis tests.
    always_comb begin
        a_right  = a_x + EDGE_W'(A_W);
        a_bottom = a_y + EDGE_W'(A_H);
        b_right  = b_x + EDGE_W'(B_W);
        b_bottom = b_y + EDGE_W'(B_H);
        overlap  = (a_x < b_right) && (b_x < a_right) &&
                   (a_y < b_bottom) && (b_y < a_bottom);
    end

endmodule

// File: rtl/laser_hit_detect.sv
// Laser vs. invader-row hit detector. Once per frame the laser rectangle is
// tested against each invader of the row, one invader per clock through a
// single rect_overlap instance. The lowest-index live invader that overlaps
// an active laser is reported as a one-hot pulse, removed from the alive
// mask and (optionally) scored.
//
// Build option: define LASER_HIT_SCORE_EN to build the saturating score
// accumulator; otherwise score is tied to zero.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | waiting for frame
// ST_LATCH  | capture laser/invader coordinates, clear scan index and hits
// ST_SCAN   | test invader idx, one per cycle, NUM_INVADERS cycles
// ST_REPORT | collision pulse visible; alive mask/score update at cycle end
module laser_hit_detect
    import laser_hit_detect_pkg::*;
#(
    parameter int NUM_INVADERS  = DEF_NUM_INVADERS,
    parameter int INV_W         = DEF_INV_W,
    parameter int INV_H         = DEF_INV_H,
    parameter int INV_PITCH     = DEF_INV_PITCH,
    parameter int LASER_W       = DEF_LASER_W,
    parameter int LASER_H       = DEF_LASER_H,
    parameter int SCORE_PER_HIT = DEF_SCORE_PER_HIT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame,
    input  logic                    respawn,
    input  logic                    laser_active,
    input  logic [COORD_W-1:0]      laser_x,
    input  logic [COORD_W-1:0]      laser_y,
    input  logic [COORD_W-1:0]      invaders_x,
    input  logic [COORD_W-1:0]      invaders_y,
    output logic [NUM_INVADERS-1:0] invader_collision,
    output logic [NUM_INVADERS-1:0] invaders_alive,
    output logic                    all_dead,
    output logic [SCORE_W-1:0]      score
);

    localparam int                IDX_W    = (NUM_INVADERS > 1) ? $clog2(NUM_INVADERS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_INVADERS - 1);

    hit_state_t state_q;
    hit_state_t state_d;

    logic [IDX_W-1:0]        idx_q;
    logic                    lat_active_q;
    logic [COORD_W-1:0]      lat_laser_x_q;
    logic [COORD_W-1:0]      lat_laser_y_q;
    logic [COORD_W-1:0]      lat_inv_x_q;
    logic [COORD_W-1:0]      lat_inv_y_q;
    logic [NUM_INVADERS-1:0] hit_mask_q;
    logic [NUM_INVADERS-1:0] alive_q;
    logic [NUM_INVADERS-1:0] coll_q;

    logic [EDGE_W-1:0]       inv_left;
    logic [EDGE_W-1:0]       inv_top;
    logic [EDGE_W-1:0]       las_left;
    logic [EDGE_W-1:0]       las_top;
    logic                    overlap;
    logic [NUM_INVADERS-1:0] idx_onehot;
    logic                    hit_now;
    logic [NUM_INVADERS-1:0] hit_vec;

    // Position of the invader under test and of the captured laser.
    always_comb begin
        inv_left   = {1'b0, lat_inv_x_q} + EDGE_W'(idx_q) * EDGE_W'(INV_PITCH);
        inv_top    = {1'b0, lat_inv_y_q};
        las_left   = {1'b0, lat_laser_x_q};
        las_top    = {1'b0, lat_laser_y_q};
        idx_onehot = NUM_INVADERS'(1) << idx_q;
    end

    rect_overlap #(
        .A_W (LASER_W),
        .A_H (LASER_H),
        .B_W (INV_W),
        .B_H (INV_H)
    ) u_rect_overlap (
        .a_x     (las_left),
        .a_y     (las_top),
        .b_x     (inv_left),
        .b_y     (inv_top),
        .overlap (overlap)
    );

    // A hit counts only for a live invader, an active laser, and only if no
    // lower-index invader already claimed this frame's hit.
    always_comb begin
        hit_now = overlap && lat_active_q && (|(alive_q & idx_onehot)) && !(|hit_mask_q);
        hit_vec = hit_mask_q | (hit_now ? idx_onehot : '0);
    end

    // Next-state logic; respawn overrides every transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (frame) state_d = ST_LATCH;
            ST_LATCH:  state_d = ST_SCAN;
            ST_SCAN:   if (idx_q == LAST_IDX) state_d = ST_REPORT;
            ST_REPORT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (respawn) state_d = ST_IDLE;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Capture, scan index, hit tracking, collision pulse and alive mask.
    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_q         <= '0;
            lat_active_q  <= 1'b0;
            lat_laser_x_q <= '0;
            lat_laser_y_q <= '0;
            lat_inv_x_q   <= '0;
            lat_inv_y_q   <= '0;
            hit_mask_q    <= '0;
            alive_q       <= '1;
            coll_q        <= '0;
        end else if (respawn) begin
            idx_q      <= '0;
            hit_mask_q <= '0;
            alive_q    <= '1;
            coll_q     <= '0;
        end else begin
            coll_q <= '0;
            case (state_q)
                ST_LATCH: begin
                    lat_active_q  <= laser_active;
                    lat_laser_x_q <= laser_x;
                    lat_laser_y_q <= laser_y;
                    lat_inv_x_q   <= invaders_x;
                    lat_inv_y_q   <= invaders_y;
                    idx_q         <= '0;
                    hit_mask_q    <= '0;
                end
                ST_SCAN: begin
                    hit_mask_q <= hit_vec;
                    if (idx_q == LAST_IDX) coll_q <= hit_vec;
                    else                   idx_q  <= idx_q + 1'b1;
                end
                ST_REPORT: alive_q <= alive_q & ~coll_q;
                default: ;
            endcase
        end
    end

`ifdef LASER_HIT_SCORE_EN
    logic [SCORE_W-1:0] score_q;
    logic [EDGE_W-1:0]  score_sum;

    assign score_sum = {1'b0, score_q} + EDGE_W'(SCORE_PER_HIT);

    // Saturating score accumulator, advanced when a reported hit retires.
    always_ff @(posedge clk) begin
        if (!rst) begin
            score_q <= '0;
        end else if (!respawn && (state_q == ST_REPORT) && (|coll_q)) begin
            score_q <= (score_sum > EDGE_W'(1023)) ? SCORE_W'(1023) : score_sum[SCORE_W-1:0];
        end
    end

    assign score = score_q;
`else
    assign score = '0;
`endif

    assign invader_collision = coll_q;
    assign invaders_alive    = alive_q;
    assign all_dead          = (alive_q == '0);

endmodule

// File: tb/tb_laser_hit_detect.sv
// Self-checking bench for laser_hit_detect: directed scenarios with literal
// expectations, then randomized frames/respawns/resets checked every cycle
// against a frame-level reference model.
module tb_laser_hit_detect;

    localparam int N = 6;
`ifdef LASER_HIT_SCORE_EN
    localparam int SC = 10;
`else
    localparam int SC = 0;
`endif

    logic         clk;
    logic         rst;
    logic         frame;
    logic         respawn;
    logic         laser_active;
    logic [9:0]   laser_x;
    logic [9:0]   laser_y;
    logic [9:0]   invaders_x;
    logic [9:0]   invaders_y;
    logic [N-1:0] invader_collision;
    logic [N-1:0] invaders_alive;
    logic         all_dead;
    logic [9:0]   score;

    int errors = 0;
    int checks = 0;

    laser_hit_detect dut (
        .clk               (clk),
        .rst               (rst),
        .frame             (frame),
        .respawn           (respawn),
        .laser_active      (laser_active),
        .laser_x           (laser_x),
        .laser_y           (laser_y),
        .invaders_x        (invaders_x),
        .invaders_y        (invaders_y),
        .invader_collision (invader_collision),
        .invaders_alive    (invaders_alive),
        .all_dead          (all_dead),
        .score             (score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: which invader (one-hot) an active laser hits, lowest index first.
    function automatic logic [N-1:0] hit_of(input bit act, input int lx, input int ly,
                                            input int ivx, input int ivy, input logic [N-1:0] alive);
        logic [N-1:0] one;
        one = 1;
        for (int i = 0; i < N; i++) begin
            int ix;
            ix = ivx + i * 48;
            if (act && alive[i] && lx < ix + 32 && ix < lx + 4 && ly < ivy + 32 && ivy < ly + 16)
                return one << i;
        end
        return '0;
    endfunction

    // Frame-level model: age counts cycles since the accepted frame pulse
    // (-1 = no frame in progress). Coordinates are taken one cycle after
    // frame, the result appears frame+8, and is retired frame+9.
    int           age = -1;
    bit           started = 0;
    logic [N-1:0] m_alive = '1;
    logic [N-1:0] m_coll = '0;
    logic [N-1:0] m_pend = '0;
    logic [N-1:0] m_prev;
    int           m_score = 0;

    always @(posedge clk) begin
        started = 1;
        if (!rst) begin
            age = -1; m_alive = '1; m_coll = '0; m_score = 0;
        end else if (respawn) begin
            age = -1; m_alive = '1; m_coll = '0;
        end else begin
            m_prev = m_coll;
            m_coll = '0;
            if (age == -1) begin
                if (frame) age = 1;
            end else if (age == 1) begin
                m_pend = hit_of(laser_active, int'(laser_x), int'(laser_y),
                                int'(invaders_x), int'(invaders_y), m_alive);
                age = 2;
            end else if (age < N + 1) begin
                age++;
            end else if (age == N + 1) begin
                m_coll = m_pend;
                age = N + 2;
            end else begin
                m_alive = m_alive & ~m_prev;
                if (m_prev != 0) m_score = (m_score + SC > 1023) ? 1023 : m_score + SC;
                age = -1;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("cyc_collision", invader_collision, m_coll);
            chk("cyc_alive", invaders_alive, m_alive);
            chk("cyc_all_dead", all_dead, m_alive == 0);
            chk("cyc_score", score, m_score);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one frame from idle; returns the collision seen in the report
    // cycle and leaves time one cycle later, when the mask has updated.
    task automatic do_frame(input bit act, input int lx, input int ly, input int ivx, input int ivy,
                            output logic [N-1:0] coll8);
        laser_active = act;
        laser_x      = 10'(lx);
        laser_y      = 10'(ly);
        invaders_x   = 10'(ivx);
        invaders_y   = 10'(ivy);
        frame        = 1'b1;
        tick();
        frame = 1'b0;
        repeat (7) tick();
        coll8 = invader_collision;
        tick();
        chk("pulse_one_cycle", invader_collision, 0);
    endtask

    logic [N-1:0] c;
    int           tx;
    int           ty;

    initial begin
        rst = 1'b0; frame = 1'b0; respawn = 1'b0; laser_active = 1'b0;
        laser_x = '0; laser_y = '0; invaders_x = '0; invaders_y = '0;
        repeat (3) tick();
        chk("reset_alive", invaders_alive, 6'b111111);
        chk("reset_coll", invader_collision, 0);
        chk("reset_score", score, 0);
        chk("reset_all_dead", all_dead, 0);
        rst = 1'b1;
        tick();

        do_frame(1, 214, 70, 100, 50, c);
        chk("hit_coll", c, 6'b000100);
        chk("hit_alive", invaders_alive, 6'b111011);
        chk("hit_score", score, SC);

        do_frame(1, 214, 70, 100, 50, c);
        chk("dead_coll", c, 0);
        chk("dead_score", score, SC);

        do_frame(1, 144, 70, 100, 50, c);
        chk("edge144_coll", c, 0);
        do_frame(1, 145, 70, 100, 50, c);
        chk("edge145_coll", c, 6'b000010);
        chk("edge145_alive", invaders_alive, 6'b111001);
        chk("edge145_score", score, 2 * SC);

        do_frame(0, 110, 60, 100, 50, c);
        chk("inactive_coll", c, 0);
        chk("inactive_alive", invaders_alive, 6'b111001);

        laser_active = 1'b1; laser_x = 10'd110; laser_y = 10'd60;
        frame = 1'b1;
        tick();
        frame = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rstmid_coll", invader_collision, 0);
        chk("rstmid_alive", invaders_alive, 6'b111111);
        chk("rstmid_score", score, 0);
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("rstmid_no_pulse", invader_collision, 0);
        end

        for (int i = 0; i < N; i++) begin
            logic [N-1:0] want;
            want = 1;
            do_frame(1, 100 + 48 * i + 10, 60, 100, 50, c);
            chk("clear_coll", c, want << i);
        end
        chk("clear_all_dead", all_dead, 1);
        chk("clear_alive", invaders_alive, 0);
        chk("clear_score", score, 6 * SC);
        respawn = 1'b1;
        tick();
        respawn = 1'b0;
        chk("respawn_alive", invaders_alive, 6'b111111);
        chk("respawn_all_dead", all_dead, 0);
        chk("respawn_score", score, 6 * SC);

        for (int k = 0; k < 4000; k++) begin
            frame   = ($urandom_range(0, 5) == 0);
            respawn = ($urandom_range(0, 79) == 0);
            rst     = ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 3) == 0) begin
                invaders_x = 10'($urandom_range(0, 1023));
                invaders_y = 10'($urandom_range(0, 1023));
            end
            if ($urandom_range(0, 2) == 0) begin
                laser_active = ($urandom_range(0, 3) != 0);
                tx = int'(invaders_x) + int'($urandom_range(0, 290)) - 10;
                ty = int'(invaders_y) + int'($urandom_range(0, 60)) - 20;
                if (tx < 0) tx = 0;
                if (tx > 1023) tx = 1023;
                if (ty < 0) ty = 0;
                if (ty > 1023) ty = 1023;
                laser_x = 10'(tx);
                laser_y = 10'(ty);
            end
            tick();
        end
        frame = 1'b0; respawn = 1'b0; rst = 1'b1;
        repeat (12) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
